// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that runs one ALU operation per command.
// Each command reads its operand(s) from the register file, drives the external
// combinational ALU, then writes the result and flags back. The architectural
// flags register and the carry-in for ADC/SBC live here.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_op/ra/rb/rd/wb         opcode, source A, source B, destination, write-back enable
//   rf_rd_en/addr, rf_rd_data  regfile read port (data valid the cycle after the strobe)
//   rf_wr_en/addr/data         regfile write port
//   alu_op/a/b/cin             ALU operation, operands and carry-in
//   alu_result/alu_flags       combinational ALU outputs
//   flags, flags_clr           architectural flags and their synchronous clear
//   done, err                  completion pulse, reserved-opcode pulse (with done)
module alu_sequencer #(
   parameter int unsigned WORDSIZE  = 16,
   parameter int unsigned REGISTERS = 16,
   parameter int unsigned FLAGW     = 8,
   localparam int unsigned RA       = $clog2(REGISTERS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_op,
   input  logic [RA-1:0]       cmd_ra,
   input  logic [RA-1:0]       cmd_rb,
   input  logic [RA-1:0]       cmd_rd,
   input  logic                cmd_wb,
   output logic                rf_rd_en,
   output logic [RA-1:0]       rf_rd_addr,
   input  logic [WORDSIZE-1:0] rf_rd_data,
   output logic                rf_wr_en,
   output logic [RA-1:0]       rf_wr_addr,
   output logic [WORDSIZE-1:0] rf_wr_data,
   output logic [3:0]          alu_op,
   output logic [WORDSIZE-1:0] alu_a,
   output logic [WORDSIZE-1:0] alu_b,
   output logic                alu_cin,
   input  logic [WORDSIZE-1:0] alu_result,
   input  logic [FLAGW-1:0]    alu_flags,
   output logic [FLAGW-1:0]    flags,
   input  logic                flags_clr,
   output logic                done,
   output logic                err
);

   localparam logic [3:0] OpCmp  = 4'h3;
   localparam logic [3:0] OpInc  = 4'h4;
   localparam logic [3:0] OpDec  = 4'h5;
   localparam logic [3:0] OpLsh  = 4'hB;
   localparam logic [3:0] OpRsh  = 4'hC;
   localparam logic [3:0] OpRsvd = 4'hD;

   // Flag bits 6..7 are reserved and never stored.
   localparam logic [FLAGW-1:0] FlagMask = FLAGW'(6'h3F);

   typedef enum logic [2:0] {StIdle, StRda, StRdb, StExec, StWb} state_e;

   state_e               state_q;
   logic [RA-1:0]        rb_q;
   logic [RA-1:0]        rd_q;
   logic                 wb_q;
   logic [WORDSIZE-1:0]  opa_q;
   logic [FLAGW-1:0]     flag_hold_q;

   logic                 reserved;
   logic                 one_operand;

   // alu_op doubles as the latched opcode for the whole command.
   assign reserved    = (alu_op >= OpRsvd);
   assign one_operand = (alu_op == OpInc) || (alu_op == OpDec) || (alu_op == OpLsh) ||
                        (alu_op == OpRsh) || reserved;

   // Carry only changes on the edge ending WB or via flags_clr, so it is stable in EXEC.
   assign alu_cin = flags[0];

   // The second (or only) operand arrives from the regfile during EXEC itself, so the
   // ALU operands are steered combinationally rather than registered first.
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      if (state_q == StExec) begin
         if (one_operand) begin
            alu_a = rf_rd_data;
         end else begin
            alu_a = opa_q;
            alu_b = rf_rd_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rb_q        <= '0;
         rd_q        <= '0;
         wb_q        <= 1'b0;
         opa_q       <= '0;
         flag_hold_q <= '0;
         cmd_ready   <= 1'b1;
         rf_rd_en    <= 1'b0;
         rf_rd_addr  <= '0;
         rf_wr_en    <= 1'b0;
         rf_wr_addr  <= '0;
         rf_wr_data  <= '0;
         alu_op      <= '0;
         flags       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         // Strobes and pulses last exactly one cycle unless re-asserted below.
         rf_rd_en   <= 1'b0;
         rf_rd_addr <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
         done       <= 1'b0;
         err        <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  alu_op     <= cmd_op;
                  rb_q       <= cmd_rb;
                  rd_q       <= cmd_rd;
                  wb_q       <= cmd_wb;
                  cmd_ready  <= 1'b0;
                  rf_rd_en   <= 1'b1;
                  rf_rd_addr <= cmd_ra;
                  state_q    <= StRda;
               end
            end
            StRda: begin
               if (one_operand) begin
                  state_q <= StExec;
               end else begin
                  rf_rd_en   <= 1'b1;
                  rf_rd_addr <= rb_q;
                  state_q    <= StRdb;
               end
            end
            StRdb: begin
               opa_q   <= rf_rd_data;
               state_q <= StExec;
            end
            StExec: begin
               flag_hold_q <= alu_flags & FlagMask;
               rf_wr_en    <= wb_q && (alu_op != OpCmp) && !reserved;
               rf_wr_addr  <= rd_q;
               rf_wr_data  <= alu_result;
               done        <= 1'b1;
               err         <= reserved;
               state_q     <= StWb;
            end
            StWb: begin
               cmd_ready <= 1'b1;
               alu_op    <= '0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         // A clear coinciding with the WB update takes priority.
         if (flags_clr) begin
            flags <= '0;
         end else if (state_q == StWb && !reserved) begin
            flags <= flag_hold_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: bench-side regfile and ALU, a command-level model that
// predicts every output each cycle, and directed commands with literal expectations.
module tb_alu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [3:0]  cmd_ra;
   logic [3:0]  cmd_rb;
   logic [3:0]  cmd_rd;
   logic        cmd_wb;
   logic        rf_rd_en;
   logic [3:0]  rf_rd_addr;
   logic [15:0] rf_rd_data;
   logic        rf_wr_en;
   logic [3:0]  rf_wr_addr;
   logic [15:0] rf_wr_data;
   logic [3:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic [7:0]  alu_flags;
   logic [7:0]  flags;
   logic        flags_clr;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   alu_sequencer #(
      .WORDSIZE (16),
      .REGISTERS(16),
      .FLAGW    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_ra    (cmd_ra),
      .cmd_rb    (cmd_rb),
      .cmd_rd    (cmd_rd),
      .cmd_wb    (cmd_wb),
      .rf_rd_en  (rf_rd_en),
      .rf_rd_addr(rf_rd_addr),
      .rf_rd_data(rf_rd_data),
      .rf_wr_en  (rf_wr_en),
      .rf_wr_addr(rf_wr_addr),
      .rf_wr_data(rf_wr_data),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_cin   (alu_cin),
      .alu_result(alu_result),
      .alu_flags (alu_flags),
      .flags     (flags),
      .flags_clr (flags_clr),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference ALU: flags carry, zero, equal, greater, less, borrow; bits 7:6 always set
   // so that the sequencer's masking is visible.
   function automatic logic [23:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
      logic [16:0] t;
      logic [7:0]  f;
      f = 8'hC0;
      case (op)
         4'h0:       t = {1'b0, a} + {1'b0, b};
         4'h1:       t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         4'h2, 4'h3: t = {1'b0, a} - {1'b0, b};
         4'h4:       t = {1'b0, a} + 17'd1;
         4'h5:       t = {1'b0, a} - 17'd1;
         4'h6:       t = {1'b0, a} - {1'b0, b} - {16'd0, cin};
         4'h7:       t = {1'b0, a & b};
         4'h8:       t = {1'b0, a | b};
         4'h9:       t = {1'b0, a ^ b};
         4'hA:       t = {1'b0, ~(a & b)};
         4'hB:       t = {a, 1'b0};
         4'hC:       t = {a[0], 1'b0, a[15:1]};
         default:    t = 17'h1FFFF;
      endcase
      f[0] = (op <= 4'h1 || op == 4'h4 || op >= 4'hB) ? t[16] : 1'b0;
      f[1] = (t[15:0] == 16'h0);
      if (op == 4'h2 || op == 4'h3 || op == 4'h6) begin
         f[2] = (a == b);
         f[3] = (a > b);
         f[4] = (a < b);
         f[5] = t[16];
      end
      return {f, t[15:0]};
   endfunction

   always_comb {alu_flags, alu_result} = alu_f(alu_op, alu_a, alu_b, alu_cin);

   // Bench regfile with a backdoor load port.
   logic [15:0] mem [16];
   logic        bd_en;
   logic [3:0]  bd_addr;
   logic [15:0] bd_data;

   always @(posedge clk) begin
      if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
      if (bd_en) mem[bd_addr] <= bd_data;
      else if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
   end

   // Command-level model: m_cnt counts the cycles left in the current command
   // (binary commands take 4 cycles after accept, one-operand/reserved take 3).
   int          m_cnt;
   logic        m_bin;
   logic [3:0]  m_op;
   logic [3:0]  m_ra;
   logic [3:0]  m_rb;
   logic [3:0]  m_rd;
   logic        m_wb;
   logic [7:0]  m_flags;
   logic [15:0] m_regs [16];
   logic [15:0] m_res;
   logic [7:0]  m_fl;
   logic        m_wr;

   function automatic logic is_binary(input logic [3:0] op);
      return !(op inside {4'h4, 4'h5, 4'hB, 4'hC}) && (op < 4'hD);
   endfunction

   always_comb begin
      {m_fl, m_res} = alu_f(m_op, m_regs[m_ra], m_bin ? m_regs[m_rb] : 16'h0, m_flags[0]);
      m_wr = m_wb && (m_op != 4'h3) && (m_op < 4'hD);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt   <= 0;
         m_flags <= 8'h00;
      end else begin
         if (m_cnt == 0) begin
            if (cmd_valid) begin
               m_cnt <= is_binary(cmd_op) ? 4 : 3;
               m_bin <= is_binary(cmd_op);
               m_op  <= cmd_op;
               m_ra  <= cmd_ra;
               m_rb  <= cmd_rb;
               m_rd  <= cmd_rd;
               m_wb  <= cmd_wb;
            end
         end else begin
            m_cnt <= m_cnt - 1;
         end
         if (flags_clr) m_flags <= 8'h00;
         else if (m_cnt == 1 && m_op < 4'hD) m_flags <= m_fl & 8'h3F;
      end
   end

   always @(posedge clk) begin
      if (bd_en) m_regs[bd_addr] <= bd_data;
      else if (rst_n && m_cnt == 1 && m_wr) m_regs[m_rd] <= m_res;
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(m_cnt == 0));
         chk("done", 32'(done), 32'(m_cnt == 1));
         chk("err", 32'(err), 32'(m_cnt == 1 && m_op >= 4'hD));
         chk("rf_rd_en", 32'(rf_rd_en), 32'(m_cnt >= 3));
         chk("rf_rd_addr", 32'(rf_rd_addr),
             32'((m_cnt == 4 || (m_cnt == 3 && !m_bin)) ? m_ra : (m_cnt == 3) ? m_rb : 4'h0));
         chk("rf_wr_en", 32'(rf_wr_en), 32'(m_cnt == 1 && m_wr));
         if (m_cnt == 1 && m_wr) begin
            chk("rf_wr_addr", 32'(rf_wr_addr), 32'(m_rd));
            chk("rf_wr_data", 32'(rf_wr_data), 32'(m_res));
         end
         chk("alu_op", 32'(alu_op), 32'(m_cnt == 0 ? 4'h0 : m_op));
         chk("alu_a", 32'(alu_a), 32'(m_cnt == 2 ? m_regs[m_ra] : 16'h0));
         chk("alu_b", 32'(alu_b), 32'((m_cnt == 2 && m_bin) ? m_regs[m_rb] : 16'h0));
         if (m_cnt == 2) chk("alu_cin", 32'(alu_cin), 32'(m_flags[0]));
         chk("flags", 32'(flags), 32'(m_flags));
      end
   end

   // Issue one command, wait for done; lat = cycles from accept edge to done cycle.
   task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic w, input logic clr,
                        output int lat, output logic e);
      int n;
      n   = 0;
      lat = 0;
      e   = 1'b0;
      @(negedge clk);
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ra    = a;
      cmd_rb    = b;
      cmd_rd    = d;
      cmd_wb    = w;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom);
      cmd_ra    = 4'($urandom);
      cmd_rb    = 4'($urandom);
      cmd_rd    = 4'($urandom);
      cmd_wb    = 1'($urandom);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done) begin
            lat       = i;
            e         = err;
            flags_clr = clr;
            break;
         end
      end
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
   endtask

   logic [15:0] init_v [16] = '{16'h0000, 16'h0005, 16'h0003, 16'h0000,
                                16'h1234, 16'h1234, 16'h00FF, 16'hFFFF,
                                16'h0001, 16'h0001, 16'h0000, 16'hAAAA,
                                16'h0000, 16'h0000, 16'h8001, 16'h7FFF};

   task automatic chk_quiet(input string tag);
      chk({tag, "_rd_en"}, 32'(rf_rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(rf_rd_addr), 32'd0);
      chk({tag, "_wr_en"}, 32'(rf_wr_en), 32'd0);
      chk({tag, "_wr_data"}, 32'(rf_wr_data), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      chk({tag, "_flags"}, 32'(flags), 32'd0);
   endtask

   initial begin
      int   lat;
      logic e;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 4'h0;
      cmd_ra    = 4'h0;
      cmd_rb    = 4'h0;
      cmd_rd    = 4'h0;
      cmd_wb    = 1'b0;
      flags_clr = 1'b0;
      bd_en     = 1'b0;
      bd_addr   = 4'h0;
      bd_data   = 16'h0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bd_en   = 1'b1;
         bd_addr = 4'(i);
         bd_data = init_v[i];
      end
      @(negedge clk);
      bd_en = 1'b0;
      chk_quiet("reset");
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", 32'(cmd_ready), 32'd1);

      // ADD 5 + 3 -> r3
      issue(4'h0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, lat, e);
      chk("add_lat", 32'(lat), 32'd4);
      chk("add_err", 32'(e), 32'd0);
      chk("add_data", 32'(mem[3]), 32'h0008);
      chk("add_flags", 32'(flags), 32'h00);
      // ADD FFFF + 1 -> r10: carry and zero
      issue(4'h0, 4'd7, 4'd8, 4'd10, 1'b1, 1'b0, lat, e);
      chk("addc_data", 32'(mem[10]), 32'h0000);
      chk("addc_flags", 32'(flags), 32'h03);
      // ADC 1 + 1 + carry -> r13
      issue(4'h1, 4'd8, 4'd9, 4'd13, 1'b1, 1'b0, lat, e);
      chk("adc_data", 32'(mem[13]), 32'h0003);
      chk("adc_flags", 32'(flags), 32'h00);
      // CMP equal operands with wb=1: r11 untouched
      issue(4'h3, 4'd4, 4'd5, 4'd11, 1'b1, 1'b0, lat, e);
      chk("cmp_lat", 32'(lat), 32'd4);
      chk("cmp_nowrite", 32'(mem[11]), 32'hAAAA);
      chk("cmp_flags", 32'(flags), 32'h06);
      // INC 0x00FF -> r12, unary path
      issue(4'h4, 4'd6, 4'd0, 4'd12, 1'b1, 1'b0, lat, e);
      chk("inc_lat", 32'(lat), 32'd3);
      chk("inc_data", 32'(mem[12]), 32'h0100);
      chk("inc_flags", 32'(flags), 32'h00);
      // Set carry+zero, then a reserved opcode must leave flags and r1 alone
      issue(4'h0, 4'd7, 4'd8, 4'd0, 1'b1, 1'b0, lat, e);
      chk("pre_rsvd_flags", 32'(flags), 32'h03);
      issue(4'hD, 4'd1, 4'd2, 4'd1, 1'b1, 1'b0, lat, e);
      chk("rsvd_lat", 32'(lat), 32'd3);
      chk("rsvd_err", 32'(e), 32'd1);
      chk("rsvd_nowrite", 32'(mem[1]), 32'h0005);
      chk("rsvd_flags", 32'(flags), 32'h03);
      // flags_clr on the WB edge beats the carry+zero update
      issue(4'h0, 4'd7, 4'd8, 4'd0, 1'b1, 1'b1, lat, e);
      chk("clr_flags", 32'(flags), 32'h00);
      // SUB 0x8001 - 0x7FFF -> r14 (rd == ra)
      issue(4'h2, 4'd14, 4'd15, 4'd14, 1'b1, 1'b0, lat, e);
      chk("sub_data", 32'(mem[14]), 32'h0002);
      chk("sub_flags", 32'(flags), 32'h08);
      // LSH 2 -> r2
      issue(4'hB, 4'd14, 4'd0, 4'd2, 1'b1, 1'b0, lat, e);
      chk("lsh_lat", 32'(lat), 32'd3);
      chk("lsh_data", 32'(mem[2]), 32'h0004);

      // Abort an ADD during EXEC with reset
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 4'h0;
      cmd_ra    = 4'd1;
      cmd_rb    = 4'd2;
      cmd_rd    = 4'd3;
      cmd_wb    = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk_quiet("abort");
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_nowrite", 32'(mem[3]), 32'h0008);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      // Next command runs normally: 5 + 4 -> r3
      issue(4'h0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, lat, e);
      chk("post_abort_lat", 32'(lat), 32'd4);
      chk("post_abort_data", 32'(mem[3]), 32'h0009);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
